// File: rtl/arb2_select.sv
// ---------------------------------------------------------------------------
// arb2_select
//   Two-input round-robin arbiter feeding a one-entry output register. It
//   picks at most one of sources A/B per cycle. On contention it alternates,
//   starting with A after reset. The chosen word is presented on a
//   registered valid/ready output, together with the registered select bit
//   that drives the downstream 2:1 mux. Per-source saturating grant counters
//   expose fairness to debug logic.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   a_valid/a_data    source A request, a_ready = accepted this cycle
//   b_valid/b_data    source B request, b_ready = accepted this cycle
//   y_valid/y_data    registered output word, consumed when y_ready
//   sel               registered source of y_data (0 = A, 1 = B)
//   cnt_a, cnt_b      saturating counts of words accepted from A / B
// ---------------------------------------------------------------------------
module arb2_select #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // Arbiter state: which source won the most recent accept.
    typedef enum logic {
        LAST_A = 1'b0,   // next tie goes to B
        LAST_B = 1'b1    // next tie goes to A
    } last_e;

    last_e            r_last;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_sel;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic w_load_en;
    logic w_grant_a;
    logic w_grant_b;
    logic w_acc_a;
    logic w_acc_b;

    // The register can take a word when it is empty or drained this cycle.
    assign w_load_en = ~r_y_valid | y_ready;

    // A lone requester always wins. On a tie the winner is the source that
    // did not win last time. The two grants are mutually exclusive by construction.
    assign w_grant_a = a_valid & (~b_valid | (r_last == LAST_B));
    assign w_grant_b = b_valid & (~a_valid | (r_last == LAST_A));

    assign a_ready = w_load_en & w_grant_a & ~rst;
    assign b_ready = w_load_en & w_grant_b & ~rst;

    assign w_acc_a = a_valid & a_ready;
    assign w_acc_b = b_valid & b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= LAST_B;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_sel     <= 1'b0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
        end else begin
            if (w_acc_a) begin
                r_y_data  <= a_data;
                r_sel     <= 1'b0;
                r_y_valid <= 1'b1;
                r_last    <= LAST_A;
                if (r_cnt_a != {CNT_W{1'b1}})
                    r_cnt_a <= r_cnt_a + 1'b1;
            end else if (w_acc_b) begin
                r_y_data  <= b_data;
                r_sel     <= 1'b1;
                r_y_valid <= 1'b1;
                r_last    <= LAST_B;
                if (r_cnt_b != {CNT_W{1'b1}})
                    r_cnt_b <= r_cnt_b + 1'b1;
            end else if (y_ready) begin
                // Drained with nothing to replace it. Data and sel keep
                // their last values.
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign sel     = r_sel;
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;

endmodule

// File: tb/tb_arb2_select.sv
// ---------------------------------------------------------------------------
// tb_arb2_select
//   Directed scenarios followed by random traffic. The bench drives two
//   instances from the same inputs: one with the default counter width and
//   one with CNT_W=2, so that counter saturation is reached quickly. A
//   behavioural model tracks the output word, the last winner and the
//   unbounded accept counts. Expected counters are those counts clipped to
//   each instance's maximum.
// ---------------------------------------------------------------------------
module tb_arb2_select;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, y_ready;
    logic [W-1:0] a_data, b_data;

    logic         a_ready, b_ready, y_valid, sel;
    logic [W-1:0] y_data;
    logic [15:0]  cnt_a, cnt_b;

    logic         a_ready2, b_ready2, y_valid2, sel2;
    logic [W-1:0] y_data2;
    logic [1:0]   cnt_a2, cnt_b2;

    always #5 clk = ~clk;

    arb2_select #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    arb2_select #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
        .y_valid(y_valid2), .y_data(y_data2), .y_ready(y_ready),
        .sel(sel2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state
    int           m_last;     // 0 = A won last, 1 = B won last
    bit           m_yv;
    logic [W-1:0] m_yd;
    bit           m_sel;
    int           m_ca, m_cb; // unbounded accept counts

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock cycle. It starts at a negedge and ends at the next negedge.
    task automatic cycle(input bit r, input bit av, input logic [W-1:0] ad,
                         input bit bv, input logic [W-1:0] bd, input bit yr);
        int win; // -1 none, 0 A, 1 B
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        #1;
        win = -1;
        if (!r && (!m_yv || yr)) begin
            if (av && bv)  win = 1 - m_last;
            else if (av)   win = 0;
            else if (bv)   win = 1;
        end
        chk("a_ready", 32'(a_ready), 32'(win == 0));
        chk("b_ready", 32'(b_ready), 32'(win == 1));
        chk("a_ready_sat", 32'(a_ready2), 32'(win == 0));
        chk("b_ready_sat", 32'(b_ready2), 32'(win == 1));
        @(posedge clk);
        if (r) begin
            m_yv = 0; m_yd = '0; m_sel = 0; m_ca = 0; m_cb = 0; m_last = 1;
        end else if (win == 0) begin
            m_yv = 1; m_yd = ad; m_sel = 0; m_last = 0; m_ca++;
        end else if (win == 1) begin
            m_yv = 1; m_yd = bd; m_sel = 1; m_last = 1; m_cb++;
        end else if (yr) begin
            m_yv = 0;
        end
        @(negedge clk);
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("y_data",  32'(y_data),  32'(m_yd));
        chk("sel",     32'(sel),     32'(m_sel));
        chk("cnt_a",   32'(cnt_a),   32'(clip(m_ca, 65535)));
        chk("cnt_b",   32'(cnt_b),   32'(clip(m_cb, 65535)));
        chk("y_data_sat", 32'(y_data2), 32'(m_yd));
        chk("cnt_a_sat", 32'(cnt_a2), 32'(clip(m_ca, 3)));
        chk("cnt_b_sat", 32'(cnt_b2), 32'(clip(m_cb, 3)));
    endtask

    initial begin
        logic [W-1:0] d;
        m_last = 1; m_yv = 0; m_yd = '0; m_sel = 0; m_ca = 0; m_cb = 0;
        rst = 1; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; y_ready = 0;
        @(negedge clk);

        // Reset while both sources request: nothing is accepted.
        cycle(1, 1, 8'hEE, 1, 8'hDD, 1);
        cycle(1, 1, 8'hEE, 1, 8'hDD, 1);
        // First tie goes to A.
        cycle(0, 1, 8'h01, 1, 8'h02, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // A only, back to back.
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 1, 8'h11, 0, 8'h00, 1);
        cycle(0, 1, 8'h22, 0, 8'h00, 1);
        cycle(0, 1, 8'h33, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Both valid for six cycles: the grants alternate.
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 8'(8'hA0 + i), 1, 8'(8'hB0 + i), 1);

        // Stall with B's word held and A waiting, then release.
        cycle(0, 0, 8'h00, 1, 8'h5A, 1);
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 8'hC3, 0, 8'h00, 0);
        cycle(0, 1, 8'hC3, 0, 8'h00, 1);

        // Reset while the output holds a word.
        cycle(0, 1, 8'h77, 0, 8'h00, 0);
        cycle(1, 1, 8'h78, 1, 8'h79, 0);
        cycle(0, 1, 8'h81, 1, 8'h82, 1);

        // Saturation of the 2-bit counter: five A accepts.
        for (int i = 0; i < 5; i++)
            cycle(0, 1, 8'(8'h40 + i), 0, 8'h00, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            d = 8'($urandom);
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), d,
                  ($urandom_range(0, 99) < 60), 8'($urandom),
                  ($urandom_range(0, 99) < 70));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
